// File: rtl/alarm_buzzer_if.sv
// Alarm buzzer signal bundle: control strobes in, speaker drive and status out.
interface alarm_buzzer_if;
  logic tick_256;
  logic sound_alarm;
  logic mute;
  logic speaker;
  logic beeping;
  logic timed_out;

  modport master (
    output tick_256,
    output sound_alarm,
    output mute,
    input  speaker,
    input  beeping,
    input  timed_out
  );

  modport slave (
    input  tick_256,
    input  sound_alarm,
    input  mute,
    output speaker,
    output beeping,
    output timed_out
  );
endinterface

// File: rtl/alarm_buzzer.sv
// Turns the sound_alarm level into a gated square-wave beep pattern with mute and auto-timeout.
// Define ALARM_ESCALATE_EN to halve the gap length once eight beep periods have completed.
module alarm_buzzer #(
  parameter int unsigned TONE_DIV       = 6250,
  parameter int unsigned BEEP_ON_TICKS  = 64,
  parameter int unsigned BEEP_OFF_TICKS = 64,
  parameter int unsigned TIMEOUT_TICKS  = 15360
) (
  input logic           clk,
  input logic           reset,
  alarm_buzzer_if.slave bus
);

  localparam int unsigned ToneW    = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam int unsigned PhaseMax = (BEEP_ON_TICKS > BEEP_OFF_TICKS) ? BEEP_ON_TICKS
                                                                      : BEEP_OFF_TICKS;
  localparam int unsigned PhaseW   = (PhaseMax > 1) ? $clog2(PhaseMax) : 1;
  localparam int unsigned TimeoutW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

  localparam logic [ToneW-1:0]    ToneLast    = ToneW'(TONE_DIV - 1);
  localparam logic [PhaseW-1:0]   BurstLast   = PhaseW'(BEEP_ON_TICKS - 1);
  localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT_TICKS - 1);

  typedef enum logic [1:0] {StIdle, StBurst, StGap, StSilenced} state_e;

  state_e                state_q, state_d;
  logic                  s_q;
  logic [ToneW-1:0]      tone_cnt_q, tone_cnt_d;
  logic                  tone_q, tone_d;
  logic [PhaseW-1:0]     burst_cnt_q, burst_cnt_d;
  logic [TimeoutW-1:0]   timeout_q, timeout_d;
  logic                  beeping_q, beeping_d;
  logic                  timed_out_q, timed_out_d;
  logic                  rise;
  logic                  timeout_hit;
  logic                  active;
  logic [PhaseW-1:0]     gap_last;

  assign rise        = !s_q && bus.sound_alarm;
  assign active      = (state_q == StBurst) || (state_q == StGap);
  assign timeout_hit = bus.tick_256 && (timeout_q == TimeoutLast);

`ifdef ALARM_ESCALATE_EN
  localparam int unsigned GapShort = ((BEEP_OFF_TICKS >> 1) == 0) ? 1 : (BEEP_OFF_TICKS >> 1);

  logic [3:0] esc_q, esc_d;

  // Counts full burst+gap periods; from the ninth period on the gap is shortened.
  always_comb begin
    esc_d = esc_q;
    if (state_d == StIdle) begin
      esc_d = 4'd0;
    end else if (state_q == StGap && state_d == StBurst && esc_q != 4'd8) begin
      esc_d = esc_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      esc_q <= 4'd0;
    end else begin
      esc_q <= esc_d;
    end
  end

  assign gap_last = (esc_q >= 4'd8) ? PhaseW'(GapShort - 1) : PhaseW'(BEEP_OFF_TICKS - 1);
`else
  assign gap_last = PhaseW'(BEEP_OFF_TICKS - 1);
`endif

  // State register plus registered output decodes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      s_q         <= 1'b0;
      tone_cnt_q  <= '0;
      tone_q      <= 1'b0;
      burst_cnt_q <= '0;
      timeout_q   <= '0;
      beeping_q   <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= bus.sound_alarm;
      tone_cnt_q  <= tone_cnt_d;
      tone_q      <= tone_d;
      burst_cnt_q <= burst_cnt_d;
      timeout_q   <= timeout_d;
      beeping_q   <= beeping_d;
      timed_out_q <= timed_out_d;
    end
  end

  // Next state; a dropped alarm level overrides every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (rise) state_d = StBurst;
      end
      StBurst: begin
        if (bus.mute || timeout_hit) begin
          state_d = StSilenced;
        end else if (bus.tick_256 && burst_cnt_q == BurstLast) begin
          state_d = StGap;
        end
      end
      StGap: begin
        if (bus.mute || timeout_hit) begin
          state_d = StSilenced;
        end else if (bus.tick_256 && burst_cnt_q == gap_last) begin
          state_d = StBurst;
        end
      end
      StSilenced: begin
        state_d = StSilenced;
      end
    endcase
    if (!bus.sound_alarm) state_d = StIdle;
  end

  // Tone divider, phase counter and timeout counter.
  always_comb begin
    tone_cnt_d  = '0;
    tone_d      = 1'b0;
    burst_cnt_d = '0;
    timeout_d   = timeout_q;

    if (state_q == StBurst && state_d == StBurst) begin
      if (tone_cnt_q == ToneLast) begin
        tone_cnt_d = '0;
        tone_d     = ~tone_q;
      end else begin
        tone_cnt_d = tone_cnt_q + 1'b1;
        tone_d     = tone_q;
      end
    end

    if (active && state_d == state_q) begin
      burst_cnt_d = bus.tick_256 ? burst_cnt_q + 1'b1 : burst_cnt_q;
    end

    if (state_q == StIdle) begin
      timeout_d = '0;
    end else if (active && bus.tick_256 && timeout_q != TimeoutLast) begin
      timeout_d = timeout_q + 1'b1;
    end
  end

  // Output decode of the next state, registered alongside it.
  always_comb begin
    beeping_d   = (state_d == StBurst) || (state_d == StGap);
    timed_out_d = (state_d == StSilenced);
  end

  assign bus.speaker   = tone_q;
  assign bus.beeping   = beeping_q;
  assign bus.timed_out = timed_out_q;

endmodule
